// File: rtl/rob_commit_ctrl_if.sv
// -----------------------------------------------------------------------------
// rob_commit_pkg / rob_commit_ctrl_if
//
// Purpose:
//   Shared types for the commit sequencer, plus the interface that groups the
//   ROB-head, register-file, memory-store and status signals of
//   rob_commit_ctrl.
//
// Port summary (interface signals):
//   head_entry    ROB head entry (valid, wr_mem, dest_reg, value, dest_addr)
//   head_ready    head result / store operands complete
//   head_tag      ROB tag of the head
//   commit_pop    ROB frees the head at this posedge
//   rf_wr_en/idx/data/tag   register file write port
//   mem_req/addr/data       store write request
//   mem_ack       memory accepted the store this cycle
//   commit_count  retired-instruction counter
//   store_timeout sticky store-wait timeout flag
//
// Modports:
//   master : the commit controller (drives commit, rf and memory requests)
//   slave  : the surrounding ROB / register file / memory environment
// -----------------------------------------------------------------------------
package rob_commit_pkg;

    localparam int XLEN        = 32;
    localparam int ROB_TAG_LEN = 5;

    typedef struct packed {
        logic            valid;
        logic            wr_mem;
        logic [4:0]      dest_reg;
        logic [XLEN-1:0] value;
        logic [XLEN-1:0] dest_addr;
    } rob_entry_t;

endpackage

interface rob_commit_ctrl_if;

    rob_commit_pkg::rob_entry_t                      head_entry;
    logic                                            head_ready;
    logic [rob_commit_pkg::ROB_TAG_LEN-1:0]          head_tag;

    logic                                            commit_pop;

    logic                                            rf_wr_en;
    logic [4:0]                                      rf_wr_idx;
    logic [rob_commit_pkg::XLEN-1:0]                 rf_wr_data;
    logic [rob_commit_pkg::ROB_TAG_LEN-1:0]          rf_wr_tag;

    logic                                            mem_req;
    logic [rob_commit_pkg::XLEN-1:0]                 mem_addr;
    logic [rob_commit_pkg::XLEN-1:0]                 mem_data;
    logic                                            mem_ack;

    logic [31:0]                                     commit_count;
    logic                                            store_timeout;

    modport master (
        input  head_entry, head_ready, head_tag, mem_ack,
        output commit_pop,
        output rf_wr_en, rf_wr_idx, rf_wr_data, rf_wr_tag,
        output mem_req, mem_addr, mem_data,
        output commit_count, store_timeout
    );

    modport slave (
        output head_entry, head_ready, head_tag, mem_ack,
        input  commit_pop,
        input  rf_wr_en, rf_wr_idx, rf_wr_data, rf_wr_tag,
        input  mem_req, mem_addr, mem_data,
        input  commit_count, store_timeout
    );

endinterface

// File: rtl/rob_commit_ctrl.sv
// -----------------------------------------------------------------------------
// rob_commit_ctrl
//
// Purpose:
//   Commit sequencer between the ROB head and architectural state. A ready,
//   valid non-store head retires in the same cycle by writing the register
//   file (x0 destinations pop without writing). A ready store head is latched
//   and retired through a single memory write handshake; the ROB head is
//   popped in the cycle memory acknowledges it. A 32-bit retired counter and a
//   sticky store-timeout flag are maintained.
//
// Ports:
//   clock  : system clock, all state on posedge
//   reset  : asynchronous active-low reset
//   bus    : rob_commit_ctrl_if.master (head, register file, memory, status)
//
// Parameters:
//   MAX_STORE_WAIT : un-acked store cycles before store_timeout sets (>= 1)
// -----------------------------------------------------------------------------
module rob_commit_ctrl #(
    parameter int MAX_STORE_WAIT = 15
) (
    input  logic               clock,
    input  logic               reset,
    rob_commit_ctrl_if.master  bus
);

    import rob_commit_pkg::*;

    // Counter wide enough to hold MAX_STORE_WAIT; saturates there.
    localparam int            CW       = (MAX_STORE_WAIT < 1) ? 1 : $clog2(MAX_STORE_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'((MAX_STORE_WAIT < 1) ? 1 : MAX_STORE_WAIT);

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_STORE = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          wait_cnt_q, wait_cnt_d;
    logic [XLEN-1:0]        addr_q, addr_d;
    logic [XLEN-1:0]        data_q, data_d;
    logic [31:0]            count_q, count_d;
    logic                   timeout_q, timeout_d;

    logic                   head_go_s;
    logic                   commit_pop_s;
    logic                   rf_wr_en_s;
    logic [4:0]             rf_wr_idx_s;
    logic [XLEN-1:0]        rf_wr_data_s;
    logic [ROB_TAG_LEN-1:0] rf_wr_tag_s;
    logic                   mem_req_s;
    logic [XLEN-1:0]        mem_addr_s;
    logic [XLEN-1:0]        mem_data_s;

    // Next-state and Mealy output decode for the commit FSM.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        commit_pop_s = 1'b0;
        rf_wr_en_s   = 1'b0;
        rf_wr_idx_s  = 5'd0;
        rf_wr_data_s = {XLEN{1'b0}};
        rf_wr_tag_s  = {ROB_TAG_LEN{1'b0}};
        mem_req_s    = 1'b0;
        mem_addr_s   = {XLEN{1'b0}};
        mem_data_s   = {XLEN{1'b0}};
        head_go_s    = bus.head_entry.valid & bus.head_ready;

        case (state_q)
            S_RUN: begin
                rf_wr_idx_s  = bus.head_entry.dest_reg;
                rf_wr_data_s = bus.head_entry.value;
                rf_wr_tag_s  = bus.head_tag;
                if (head_go_s && !bus.head_entry.wr_mem) begin
                    // Register commit retires in the same cycle; x0 pops silently.
                    commit_pop_s = 1'b1;
                    rf_wr_en_s   = (bus.head_entry.dest_reg != 5'd0);
                end else if (head_go_s && bus.head_entry.wr_mem) begin
                    // Capture store operands so the head may change while waiting.
                    addr_d     = bus.head_entry.dest_addr;
                    data_d     = bus.head_entry.value;
                    wait_cnt_d = {CW{1'b0}};
                    state_d    = S_STORE;
                end else begin
                    state_d = S_RUN;
                end
            end

            S_STORE: begin
                mem_req_s  = 1'b1;
                mem_addr_s = addr_q;
                mem_data_s = data_q;
                if (bus.mem_ack) begin
                    commit_pop_s = 1'b1;
                    state_d      = S_RUN;
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end else begin
                    wait_cnt_d = wait_cnt_q;
                end
            end

            default: begin
                state_d = S_RUN;
            end
        endcase

        count_d = count_q + {31'd0, commit_pop_s};

        // Flag rises on the edge where the counter lands on the limit; sticky.
        if ((state_q == S_STORE) && (wait_cnt_d == WAIT_MAX)) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // State, operand latches, retired counter and timeout flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_RUN;
            wait_cnt_q <= {CW{1'b0}};
            addr_q     <= {XLEN{1'b0}};
            data_q     <= {XLEN{1'b0}};
            count_q    <= 32'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            count_q    <= count_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.commit_pop    = commit_pop_s;
    assign bus.rf_wr_en      = rf_wr_en_s;
    assign bus.rf_wr_idx     = rf_wr_idx_s;
    assign bus.rf_wr_data    = rf_wr_data_s;
    assign bus.rf_wr_tag     = rf_wr_tag_s;
    assign bus.mem_req       = mem_req_s;
    assign bus.mem_addr      = mem_addr_s;
    assign bus.mem_data      = mem_data_s;
    assign bus.commit_count  = count_q;
    assign bus.store_timeout = timeout_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rob_commit_ctrl
//
// Scoreboard bench for rob_commit_ctrl. Stimulus tasks push the expected
// commit (cycle, kind, rf / memory payload) into a queue; a negedge monitor
// pops an entry on every commit_pop and checks mem_addr/mem_data on every
// mem_req cycle against the pending store.
// -----------------------------------------------------------------------------
module tb_rob_commit_ctrl;

    import rob_commit_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    rob_commit_ctrl_if bus();

    rob_commit_ctrl #(.MAX_STORE_WAIT(15)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        bit          is_store;
        bit          we;
        logic [4:0]  idx;
        logic [31:0] data;
        logic [4:0]  tag;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   failed    = 0;
    int   cyc       = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests_run++;
        failed++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // Monitor: compare every presented commit / store request with the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            if (bus.mem_req) begin
                if (sb.size() == 0 || !sb[0].is_store) begin
                    fail_now("mem_req_unexpected");
                end else begin
                    chk("mem_addr", bus.mem_addr, sb[0].addr);
                    chk("mem_data", bus.mem_data, sb[0].data);
                end
            end
            if (bus.commit_pop) begin
                if (sb.size() == 0) begin
                    fail_now("stray_pop");
                end else begin
                    e = sb.pop_front();
                    chk("pop_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.is_store) begin
                        chk("store_pop_ack", {31'd0, bus.mem_ack}, 32'd1);
                        chk("store_pop_rf_wr_en", {31'd0, bus.rf_wr_en}, 32'd0);
                    end else begin
                        chk("alu_pop_mem_req", {31'd0, bus.mem_req}, 32'd0);
                        chk("rf_wr_en", {31'd0, bus.rf_wr_en}, {31'd0, e.we});
                        if (e.we) begin
                            chk("rf_wr_idx",  {27'd0, bus.rf_wr_idx}, {27'd0, e.idx});
                            chk("rf_wr_data", bus.rf_wr_data, e.data);
                            chk("rf_wr_tag",  {27'd0, bus.rf_wr_tag}, {27'd0, e.tag});
                        end
                    end
                end
            end else if (bus.rf_wr_en) begin
                fail_now("rf_wr_without_pop");
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic idle_head();
        bus.head_entry = '0;
        bus.head_ready = 1'b0;
        bus.head_tag   = 5'd0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_head();
        bus.mem_ack = 1'b0;
        sb.delete();
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    task automatic drive_alu(input logic [4:0] d, input logic [31:0] v, input logic [4:0] t);
        exp_t e;
        bus.head_entry           = '0;
        bus.head_entry.valid     = 1'b1;
        bus.head_entry.wr_mem    = 1'b0;
        bus.head_entry.dest_reg  = d;
        bus.head_entry.value     = v;
        bus.head_entry.dest_addr = 32'hDEAD_BEEF;
        bus.head_ready           = 1'b1;
        bus.head_tag             = t;
        e.cyc = cyc; e.is_store = 1'b0; e.we = (d != 5'd0);
        e.idx = d; e.data = v; e.tag = t; e.addr = 32'd0;
        sb.push_back(e);
        step();
    endtask

    task automatic set_store_head(input logic [31:0] a, input logic [31:0] v, input logic [4:0] t);
        bus.head_entry           = '0;
        bus.head_entry.valid     = 1'b1;
        bus.head_entry.wr_mem    = 1'b1;
        bus.head_entry.dest_reg  = 5'd7;
        bus.head_entry.value     = v;
        bus.head_entry.dest_addr = a;
        bus.head_ready           = 1'b1;
        bus.head_tag             = t;
    endtask

    task automatic push_store(input int pop_cyc, input logic [31:0] a, input logic [31:0] v);
        exp_t e;
        e.cyc = pop_cyc; e.is_store = 1'b1; e.we = 1'b0;
        e.idx = 5'd0; e.data = v; e.tag = 5'd0; e.addr = a;
        sb.push_back(e);
    endtask

    // Store head, then 'delay' un-acked cycles with garbage on the head, then ack.
    task automatic drive_store(input logic [31:0] a, input logic [31:0] v, input logic [4:0] t,
                               input int delay);
        set_store_head(a, v, t);
        bus.mem_ack = 1'b0;
        push_store(cyc + 1 + delay, a, v);
        step();
        for (int i = 0; i < delay; i++) begin
            bus.head_entry.valid     = 1'b1;
            bus.head_entry.wr_mem    = 1'($urandom);
            bus.head_entry.dest_reg  = 5'($urandom_range(1, 31));
            bus.head_entry.value     = $urandom;
            bus.head_entry.dest_addr = $urandom;
            bus.head_ready           = 1'b1;
            bus.head_tag             = 5'($urandom);
            bus.mem_ack              = 1'b0;
            #1;
            chk("store_wait_req", {31'd0, bus.mem_req}, 32'd1);
            chk("store_wait_nopop", {31'd0, bus.commit_pop}, 32'd0);
            step();
        end
        idle_head();
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        int c;
        idle_head();
        bus.mem_ack = 1'b0;
        do_reset();

        // Reset state.
        chk("rst_commit_pop", {31'd0, bus.commit_pop}, 32'd0);
        chk("rst_rf_wr_en", {31'd0, bus.rf_wr_en}, 32'd0);
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_timeout", {31'd0, bus.store_timeout}, 32'd0);
        chk("rst_count", bus.commit_count, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);

        // Register commit and x0 commit.
        drive_alu(5'd3, 32'd5, 5'd0);
        chk("count_after_alu", bus.commit_count, 32'd1);
        drive_alu(5'd0, 32'd9, 5'd2);
        chk("count_after_x0", bus.commit_count, 32'd2);

        // No-commit conditions: ready without valid, valid without ready, stray ack.
        idle_head();
        bus.head_ready = 1'b1;
        step();
        bus.head_entry.valid = 1'b1;
        bus.head_ready       = 1'b0;
        step();
        idle_head();
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        chk("count_no_commit", bus.commit_count, 32'd2);

        // Store held 2 cycles, garbage head while waiting.
        drive_store(32'h11, 32'h10, 5'd4, 2);
        chk("count_after_store", bus.commit_count, 32'd3);
        chk("mem_req_idle", {31'd0, bus.mem_req}, 32'd0);
        chk("mem_addr_idle", bus.mem_addr, 32'd0);
        chk("mem_data_idle", bus.mem_data, 32'd0);

        // Back-to-back: 3 ALU, immediate-ack store, ALU -> count 5.
        do_reset();
        drive_alu(5'd1, 32'hA1, 5'd1);
        drive_alu(5'd2, 32'hA2, 5'd2);
        drive_alu(5'd31, 32'hFFFF_FFFF, 5'd31);
        drive_store(32'h8000_0040, 32'h1234_5678, 5'd5, 0);
        drive_alu(5'd4, 32'hA4, 5'd6);
        idle_head();
        chk("count_sequence", bus.commit_count, 32'd5);

        // Timeout: 20 un-acked cycles, flag on the 15th, ack later, flag sticky.
        do_reset();
        c = cyc;
        set_store_head(32'h0000_0100, 32'hCAFE_F00D, 5'd9);
        push_store(c + 21, 32'h0000_0100, 32'hCAFE_F00D);
        step();
        for (int i = 1; i <= 20; i++) begin
            idle_head();
            bus.mem_ack = 1'b0;
            step();
            if (i == 14) chk("timeout_before_15", {31'd0, bus.store_timeout}, 32'd0);
            if (i == 15) chk("timeout_at_15", {31'd0, bus.store_timeout}, 32'd1);
        end
        chk("timeout_req_held", {31'd0, bus.mem_req}, 32'd1);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        chk("timeout_sticky", {31'd0, bus.store_timeout}, 32'd1);
        chk("timeout_count", bus.commit_count, 32'd1);
        chk("timeout_back_run", {31'd0, bus.mem_req}, 32'd0);

        // Asynchronous reset in the middle of a store.
        set_store_head(32'h44, 32'h55, 5'd3);
        push_store(cyc + 100, 32'h44, 32'h55);
        step();
        idle_head();
        step();
        reset = 1'b0;
        sb.delete();
        #1;
        chk("arst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("arst_pop", {31'd0, bus.commit_pop}, 32'd0);
        chk("arst_count", bus.commit_count, 32'd0);
        chk("arst_timeout", {31'd0, bus.store_timeout}, 32'd0);
        chk("arst_mem_addr", bus.mem_addr, 32'd0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        drive_alu(5'd6, 32'h66, 5'd7);
        idle_head();
        chk("count_after_arst", bus.commit_count, 32'd1);

        step();
        if (sb.size() != 0) fail_now("scoreboard_not_drained");
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
